// File: rtl/skolem_sweep_ctrl.sv
// skolem_sweep_ctrl
//   Exhaustive checker sequencer for a combinational Skolem-function netlist.
//   It walks x_out through every assignment of the universal inputs. Each
//   vector is held for SETTLE cycles, and then the formula evaluator's verdict
//   (phi_in) is sampled. The sweep stops at the first counterexample or after
//   the all-ones vector. It reports pass/fail, the failing vector and the
//   Skolem output seen there.
//
// Ports
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   start          begin a sweep (accepted only in IDLE or DONE)
//   abort          cancel and clear results (accepted in every state)
//   x_out          current assignment driven onto the shared input bus
//   y_in           Skolem output for x_out
//   phi_in         formula value for (x_out, y_in); 1 = holds
//   busy           sweep in progress
//   done           sweep finished; held until the next accepted start or abort
//   pass           valid with done; 1 = every vector satisfied phi
//   cex, cex_y     failing vector and y_in at it (0 unless done && !pass)
//   vec_cnt        vectors sampled in the current or last sweep
//   state_dbg      FSM state for checkers (0 IDLE, 1 RUN, 2 DONE)
//
// Control semantics: start and abort are level-sampled on each rising edge.
// There is no handshake back to the host. Abort wins over start and over a
// final sample on the same edge. A start seen while RUN is dropped.

module skolem_sweep_ctrl #(
  parameter int N_IN   = 8,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] x_out,
  input  logic            y_in,
  input  logic            phi_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN-1:0] cex,
  output logic            cex_y,
  output logic [N_IN:0]   vec_cnt,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // The settle counter counts down to 0. The edge at which it reads 0 is the
  // sampling edge, so a reload value of SETTLE-1 holds each vector SETTLE edges.
  localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

  state_t            state_q, state_d;
  logic [N_IN-1:0]   x_q, x_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [N_IN-1:0]   cex_q, cex_d;
  logic              cex_y_q, cex_y_d;
  logic [N_IN:0]     vec_cnt_q, vec_cnt_d;
  logic [3:0]        cnt_q, cnt_d;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    cex_d     = cex_q;
    cex_y_d   = cex_y_q;
    vec_cnt_d = vec_cnt_q;
    cnt_d     = cnt_q;

    if (abort) begin
      // x_out deliberately keeps its value so the host can see where it stopped.
      state_d   = S_IDLE;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      pass_d    = 1'b0;
      cex_d     = '0;
      cex_y_d   = 1'b0;
      vec_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d   = S_RUN;
            x_d       = '0;
            busy_d    = 1'b1;
            done_d    = 1'b0;
            pass_d    = 1'b0;
            cex_d     = '0;
            cex_y_d   = 1'b0;
            vec_cnt_d = '0;
            cnt_d     = RELOAD;
          end
        end
        S_RUN: begin
          if (cnt_q == 4'd0) begin
            vec_cnt_d = vec_cnt_q + (N_IN+1)'(1);
            if (!phi_in) begin
              state_d = S_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              pass_d  = 1'b0;
              cex_d   = x_q;
              cex_y_d = y_in;
            end else if (&x_q) begin
              // The last vector passed. x_out stays all-ones and never wraps.
              state_d = S_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              pass_d  = 1'b1;
            end else begin
              x_d   = x_q + N_IN'(1);
              cnt_d = RELOAD;
            end
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      cex_q     <= '0;
      cex_y_q   <= 1'b0;
      vec_cnt_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      cex_q     <= cex_d;
      cex_y_q   <= cex_y_d;
      vec_cnt_q <= vec_cnt_d;
      cnt_q     <= cnt_d;
    end
  end

  assign x_out     = x_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign cex       = cex_q;
  assign cex_y     = cex_y_q;
  assign vec_cnt   = vec_cnt_q;
  assign state_dbg = state_q;

endmodule

// File: doc/skolem_sweep_ctrl.md
Name: skolem_sweep_ctrl

Overview:
Sequential verification controller for the combinational Skolem-function netlists in this codebase.
- Enumerates every assignment of the universal inputs and drives it onto the shared input bus of one Skolem-function instance and its formula evaluator.
- After a settle delay, samples the evaluator's verdict for each assignment.
- Stops at the first counterexample or after the last assignment, and reports pass/fail, the failing vector and the Skolem output at that vector.
- Sits between a host/test sequencer and the synthesized Skolem block plus its phi-checker.

Parameters:
- N_IN, 8, number of universal inputs driven onto the Skolem function (i0..i(N_IN-1)).
- SETTLE, 1, cycles each vector is held before phi_in is sampled; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a sweep; honoured only in IDLE or DONE.
- abort  input  1  cancel the sweep; honoured in every state.
- x_out  output  N_IN  current assignment driven to the Skolem function and the evaluator.
- y_in  input  1  Skolem function output for x_out (e.g. i8).
- phi_in  input  1  formula value for (x_out, y_in); 1 = holds.
- busy  output  1  sweep in progress.
- done  output  1  sweep finished; held until the next accepted start or abort.
- pass  output  1  valid when done; 1 = all 2^N_IN vectors satisfied phi.
- cex  output  N_IN  failing vector when done and !pass; 0 otherwise.
- cex_y  output  1  y_in captured at the failing vector; 0 otherwise.
- vec_cnt  output  N_IN+1  number of vectors sampled in the current or last sweep.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; x_out, busy, done, pass, cex, cex_y and vec_cnt all 0. Reset mid-sweep discards everything.
- States: IDLE, RUN, DONE.
- IDLE/DONE -> RUN on an edge with start=1 and abort=0. At that edge:
  - x_out<=0, busy<=1, done<=0, pass<=0, cex<=0, cex_y<=0, vec_cnt<=0;
  - the settle counter is loaded with SETTLE-1.
- RUN:
  - The settle counter decrements each edge.
  - On the edge where the counter is 0, phi_in and y_in are sampled and vec_cnt increments.
  - Each vector is therefore sampled exactly SETTLE edges after x_out changed.
- Sample outcomes (all at the sampling edge):
  - phi_in=0: go to DONE; busy<=0, done<=1, pass<=0, cex<=x_out, cex_y<=y_in.
  - phi_in=1 and x_out all-ones: go to DONE; busy<=0, done<=1, pass<=1.
  - Otherwise: x_out<=x_out+1, counter reloads SETTLE-1.
  - x_out never wraps within a sweep.
- x_out holds its last value in DONE and in IDLE after abort. It resets to 0 only on rst_n or an accepted start.
- Latency: with start accepted at edge S, vector k is sampled at edge S+(k+1)*SETTLE. A full passing sweep asserts done after edge S+2^N_IN*SETTLE, with vec_cnt=2^N_IN.
- start while in RUN: ignored.
- abort=1 in any state: next edge -> IDLE; busy, done, pass, cex, cex_y, vec_cnt cleared. abort has priority over start and over a simultaneous final sample.
- All outputs are registered; no combinational path from any input to any output.
- phi_in and y_in are sampled only at the sampling edge; their values on other edges are don't-care.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0. Assert rst_n low mid-sweep at vector 0x30 -> outputs 0 immediately, state IDLE.
- N_IN=8, SETTLE=1, correct NAND Skolem (y=~&x) with phi=(y==~&x); start pulse at edge S:
  - done=1 and pass=1 after edge S+256;
  - vec_cnt=256, x_out=0xFF, busy low from the same edge.
- Faulty Skolem (y=1 for all x): fail at the last vector -> pass=0, cex=0xFF, cex_y=1, vec_cnt=256.
- Fault injected only at x=0x05 -> done after edge S+6; cex=0x05, vec_cnt=6.
- SETTLE=3 with a correct Skolem:
  - x_out changes every 3 cycles; done after edge S+768.
  - A start pulse at edge S+100 is ignored (vec_cnt keeps counting, no restart).
- abort at vector 0x40 -> next edge busy=0, done=0, vec_cnt=0. A new start then completes a normal passing sweep.
- abort and start asserted together in DONE -> IDLE with results cleared, no sweep started.
